// File: rtl/sponge_io_pkg.sv
// Shared definitions for the masked sponge I/O block.
//   state_e      : sequencer states (IDLE, ABSORB, ALIGN, PERM, SQUEEZE)
//   state_words  : number of stream words in the permutation state
//   cnt_width    : bits needed for a counter running 0..n-1
//   params_ok    : parameter legality test used at elaboration
package sponge_io_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ABSORB  = 3'd1,
        ALIGN   = 3'd2,
        PERM    = 3'd3,
        SQUEEZE = 3'd4
    } state_e;

    function automatic int state_words(input int state_w, input int word_w);
        return state_w / word_w;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int shares, input int word_w,
                                     input int state_w, input int rate_words);
        if (shares < 1 || word_w < 1) return 1'b0;
        if ((state_w % word_w) != 0) return 1'b0;
        return (rate_words >= 1) && (rate_words < (state_w / word_w));
    endfunction

endpackage

// File: rtl/sponge_share_reg.sv
// One Boolean share of the sponge state held as a word-rotating register.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : zero the whole share
//   shift_i       : rotate right by one word; the low word re-enters at the top
//   xor_en_i      : during a shift, XOR word_i into the word re-entering the top
//   load_i        : replace the share with load_val_i (wins over shift)
//   word_i        : absorb word for this share
//   load_val_i    : permuted state for this share
//   state_o       : full share contents, word 0 in the low bits
module sponge_share_reg #(
    parameter int WORD_W  = 32,
    parameter int STATE_W = 1600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic               xor_en_i,
    input  logic               load_i,
    input  logic [WORD_W-1:0]  word_i,
    input  logic [STATE_W-1:0] load_val_i,
    output logic [STATE_W-1:0] state_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [WORD_W-1:0]  low_word;
    logic [WORD_W-1:0]  top_word;

    assign low_word = state_q[WORD_W-1:0];
    assign top_word = xor_en_i ? (low_word ^ word_i) : low_word;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (shift_i) begin
            state_d = {top_word, state_q[STATE_W-1:WORD_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/masked_sponge_io.sv
// Masked sponge I/O: holds SHARES Boolean shares of the Keccak state and
// sequences absorb -> re-align -> permute -> squeeze between a word stream
// front end and an external masked permutation core.
//   clk, rst           : clock, synchronous active-high reset
//   init               : clear shares and abort, highest priority
//   din_valid/ready    : absorb word stream, din packs share s at [s*WORD_W +: WORD_W]
//   go_squeeze         : start final permutation and enter squeeze
//   dout_valid/ready   : squeeze word stream, same packing as din
//   perm_start/done    : permutation core handshake
//   perm_din/perm_dout : shared state to/from the core
//   busy               : high in ALIGN or PERM
//   err                : one-cycle pulse on a rejected go_squeeze
module masked_sponge_io
    import sponge_io_pkg::*;
#(
    parameter int SHARES     = 2,
    parameter int WORD_W     = 32,
    parameter int STATE_W    = 1600,
    parameter int RATE_WORDS = 34
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init,
    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [SHARES*WORD_W-1:0]  din,
    input  logic                      go_squeeze,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [SHARES*WORD_W-1:0]  dout,
    output logic                      perm_start,
    input  logic                      perm_done,
    output logic [SHARES*STATE_W-1:0] perm_din,
    input  logic [SHARES*STATE_W-1:0] perm_dout,
    output logic                      busy,
    output logic                      err
);

    localparam int STATE_WORDS = state_words(STATE_W, WORD_W);
    localparam int CNT_W       = cnt_width(STATE_WORDS);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_WORDS - 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(STATE_WORDS - 1);

    if (!params_ok(SHARES, WORD_W, STATE_W, RATE_WORDS)) begin : g_bad_params
        $error("masked_sponge_io: illegal SHARES/WORD_W/STATE_W/RATE_WORDS");
    end

    state_e           state_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic             pending_q;
    logic             perm_start_q;
    logic             err_q;

    logic din_fire;
    logic dout_fire;
    logic align_step;
    logic load_en;
    logic shift_en;

    // A go_squeeze in IDLE takes precedence, so the word offered alongside it
    // must not be accepted.
    assign din_ready  = (state_q == ABSORB) || ((state_q == IDLE) && !go_squeeze);
    assign dout_valid = (state_q == SQUEEZE);
    assign busy       = (state_q == ALIGN) || (state_q == PERM);
    assign perm_start = perm_start_q;
    assign err        = err_q;

    assign din_fire   = din_valid && din_ready && !init;
    assign dout_fire  = dout_valid && dout_ready && !init;
    assign align_step = (state_q == ALIGN) && !init;
    assign load_en    = (state_q == PERM) && perm_done && !init;
    assign shift_en   = din_fire || dout_fire || align_step;

    genvar gi;
    for (gi = 0; gi < SHARES; gi++) begin : g_share
        logic [STATE_W-1:0] share_state;

        sponge_share_reg #(
            .WORD_W  (WORD_W),
            .STATE_W (STATE_W)
        ) u_share_reg (
            .clk        (clk),
            .rst        (rst),
            .clear_i    (init),
            .shift_i    (shift_en),
            .xor_en_i   (din_fire),
            .load_i     (load_en),
            .word_i     (din[gi*WORD_W +: WORD_W]),
            .load_val_i (perm_dout[gi*STATE_W +: STATE_W]),
            .state_o    (share_state)
        );

        assign perm_din[gi*STATE_W +: STATE_W] = share_state;
        assign dout[gi*WORD_W +: WORD_W]       = share_state[WORD_W-1:0];
    end

    // word_cnt counts rotations since the state was last in lane order; a full
    // lap (rate words plus the ALIGN words) brings it back to zero.
    always_ff @(posedge clk) begin
        if (rst || init) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            pending_q    <= 1'b0;
            perm_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE, ABSORB: begin
                    if (go_squeeze && (state_q == IDLE)) begin
                        pending_q    <= 1'b1;
                        state_q      <= PERM;
                        perm_start_q <= 1'b1;
                    end else begin
                        if (go_squeeze) begin
                            err_q <= 1'b1;
                        end
                        if (din_fire) begin
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                            state_q    <= (word_cnt_q == RATE_LAST) ? ALIGN : ABSORB;
                        end
                    end
                end
                ALIGN: begin
                    if (word_cnt_q == ALIGN_LAST) begin
                        word_cnt_q   <= '0;
                        state_q      <= PERM;
                        perm_start_q <= 1'b1;
                    end else begin
                        word_cnt_q <= word_cnt_q + CNT_W'(1);
                    end
                end
                PERM: begin
                    if (perm_done) begin
                        state_q <= pending_q ? SQUEEZE : IDLE;
                    end
                end
                SQUEEZE: begin
                    if (dout_fire) begin
                        word_cnt_q <= word_cnt_q + CNT_W'(1);
                        if (word_cnt_q == RATE_LAST) begin
                            state_q <= ALIGN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/masked_sponge_io.md
Name: masked_sponge_io

Overview:
- Parametrised successor to the fixed two-share, 32-bit Keccak state register pair.
- Holds SHARES Boolean shares of the 1600-bit Keccak state as word-rotating shift registers.
- Runs the absorb, re-align, permute and squeeze sequence autonomously via an FSM with valid/ready streams.
- Sits between the bus/DMA front end and the masked Keccak-f[1600] permutation core.

Parameters:
- SHARES, 2: number of Boolean shares (≥1).
- WORD_W, 32: stream word width; must divide STATE_W.
- STATE_W, 1600: permutation state width.
- RATE_WORDS, 34: rate in words (34 = SHA3-256 at 32 bits); 1 ≤ RATE_WORDS < STATE_W/WORD_W.
- Derived constant: STATE_WORDS = STATE_W/WORD_W (50 at defaults).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- init  in  1  pulse: clear all shares and abort any operation, return to IDLE.
- din_valid  in  1  absorb word valid.
- din_ready  out  1  absorb word accepted this cycle when din_valid=1.
- din  in  SHARES*WORD_W  absorb word shares; share s occupies bits [s*WORD_W +: WORD_W].
- go_squeeze  in  1  pulse: padding is complete, permute and enter squeeze.
- dout_valid  out  1  squeeze word valid.
- dout_ready  in  1  squeeze word consumed.
- dout  out  SHARES*WORD_W  current low word of every share, same packing as din.
- perm_start  out  1  single-cycle start to the permutation core.
- perm_done  in  1  single-cycle pulse: perm_dout is valid.
- perm_din  out  SHARES*STATE_W  shared state presented to the core.
- perm_dout  in  SHARES*STATE_W  permuted shared state.
- busy  out  1  high in ALIGN or PERM.
- err  out  1  one-cycle pulse when go_squeeze is rejected.

Behaviour:
- Reset and init both force: all shares to 0, word_cnt to 0, state IDLE.
- Output reset values: din_ready=1, dout_valid=0, perm_start=0, busy=0, err=0.
- init has priority over every other input, in every state, including PERM.
- If perm_done arrives after init, it is ignored.

- Shift step (one per accepted or consumed word), per share s:
  - The register rotates right by WORD_W.
  - The new top word is low_word XOR din_s during absorb, and low_word unchanged otherwise.
  - word_cnt increments by 1.
- States:
  - IDLE/ABSORB: din_ready=1.
    - Each din handshake XOR-absorbs and shifts.
    - When word_cnt reaches RATE_WORDS, go to ALIGN with return target PERM→IDLE.
  - ALIGN: plain rotation, one word per cycle, no inputs accepted.
    - Lasts STATE_WORDS−RATE_WORDS cycles, 16 at defaults.
    - The state is back in lane order afterwards; word_cnt returns to 0.
    - Then go to PERM.
  - PERM: perm_start is high for the first cycle only; perm_din is wired to the share registers at all times.
    - On perm_done, load perm_dout into the shares.
    - Next state is IDLE, or SQUEEZE if a squeeze is pending.
  - SQUEEZE: dout_valid=1.
    - Each dout handshake shifts without XOR.
    - At word_cnt=RATE_WORDS go to ALIGN, then PERM, then SQUEEZE: XOF extension, unbounded until init.
    - din_ready=0 throughout SQUEEZE.
- go_squeeze:
  - Accepted only in IDLE with word_cnt=0, i.e. whole blocks absorbed with padding done by software. It then sets squeeze pending and goes to PERM.
  - In IDLE with word_cnt≠0 it pulses err and changes nothing.
  - In any other state it is ignored without err.
  - If go_squeeze and a din handshake occur in the same cycle in IDLE, go_squeeze wins and the din word is not accepted (din_ready=0 that cycle).
- Latency:
  - Absorb block to ready again: RATE_WORDS handshakes, plus 16 ALIGN cycles, plus 1 + core latency.
  - First dout_valid: the cycle after the perm_done load.
- Shares are never combined; no logic mixes share s with share t.

Decomposition:
- Package sponge_io_pkg holds:
  - the FSM state enum (IDLE, ABSORB, ALIGN, PERM, SQUEEZE);
  - STATE_WORDS and counter-width functions;
  - parameter legality checks (elaboration assertions on divisibility and rate bounds).
- One sub-module, sponge_share_reg, is instantiated SHARES times. Its controls are:
  - clear, shift, xor_en, load;
  - its data are a WORD_W in-word, a STATE_W load value, and full-state out.
- The top level owns the FSM, word_cnt and pending flag.

Test Plan:
- rst then idle: din_ready=1, dout_valid=0, all shares 0, perm_start never asserted.
- Absorb 34 words: share0 = i, share1 = 0xA5A5A5A5, i=0..33, stub core returns its input.
  - After ALIGN, perm_din share0 lane words 0..33 = i, words 34..49 = 0.
  - perm_din share1 words 0..33 = 0xA5A5A5A5.
  - busy high for 16 ALIGN cycles + PERM.
- go_squeeze with word_cnt=5: err pulses once, state unchanged.
  - After 29 more words, the block completes normally.
- Full block absorbed, go_squeeze, stub core XORs 0xFFFF… into each share:
  - dout yields 34 complemented words, then ALIGN, PERM, and 34 more words.
  - dout_ready toggled randomly: no word lost or duplicated.
- init asserted mid-ALIGN and mid-PERM, with perm_done 3 cycles later:
  - shares are 0, state IDLE, late perm_done causes no load.
- SHARES=3, WORD_W=64, RATE_WORDS=17 (SHA3-256 at 64-bit): ALIGN lasts 8 cycles.
  - The XOR of the three shares equals the unshared reference state after absorb.
